// File: rtl/wind_pkg.sv
// wind_pkg
// Shared types and constants for the wind-direction light decoder.
//   dir_t    : direction code, identical to the light's SW encoding.
//   xclass_t : classification of one lamp-pattern transition.
//   P_*      : the four legal lamp patterns (bit 2 = left lamp).
package wind_pkg;

    typedef enum logic [1:0] {
        CALM = 2'b00,
        R2L  = 2'b01,
        L2R  = 2'b10
    } dir_t;

    typedef enum logic [2:0] {
        X_CALM    = 3'd0,
        X_R2L     = 3'd1,
        X_L2R     = 3'd2,
        X_NEUTRAL = 3'd3,
        X_ILLEGAL = 3'd4
    } xclass_t;

    localparam logic [2:0] P_L = 3'b100;
    localparam logic [2:0] P_M = 3'b010;
    localparam logic [2:0] P_R = 3'b001;
    localparam logic [2:0] P_C = 3'b101;

    // True for the four patterns the light can ever show.
    function automatic logic pattern_legal(input logic [2:0] p);
        logic ok;
        case (p)
            P_L, P_M, P_R, P_C: ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Direction implied by a directional transition class.
    function automatic dir_t xclass_to_dir(input xclass_t c);
        dir_t d;
        case (c)
            X_R2L:   d = R2L;
            X_L2R:   d = L2R;
            default: d = CALM;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wind_xition_classify.sv
// wind_xition_classify
// Purely combinational classification of one lamp-pattern transition.
// Ports:
//   prev   : previously observed legal pattern
//   cur    : newly observed pattern
//   xclass : transition class (CALM / R2L / L2R / NEUTRAL / ILLEGAL)
module wind_xition_classify
    import wind_pkg::*;
(
    input  logic [2:0] prev,
    input  logic [2:0] cur,
    output xclass_t    xclass
);

    // Transition lookup; repeats and illegal current patterns are ILLEGAL.
    always_comb begin
        xclass = X_ILLEGAL;
        if (!pattern_legal(cur) || (cur == prev)) begin
            xclass = X_ILLEGAL;
        end else begin
            case ({prev, cur})
                {P_M, P_C}, {P_C, P_M}:             xclass = X_CALM;
                {P_M, P_L}, {P_L, P_R}, {P_R, P_M}: xclass = X_R2L;
                {P_M, P_R}, {P_R, P_L}, {P_L, P_M}: xclass = X_L2R;
                {P_C, P_R}, {P_C, P_L},
                {P_R, P_C}, {P_L, P_C}:             xclass = X_NEUTRAL;
                default:                            xclass = X_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/wind_light_decoder.sv
// wind_light_decoder
// Recovers the 2-bit wind-direction code from the lamp pattern sequence of
// the wind-direction hazard light. A direction is accepted after CONFIRM
// consecutive transitions of the same class; the decode goes stale after
// TIMEOUT clocks without a step.
// Ports:
//   CLOCK_50  : clock
//   reset     : synchronous, active-high reset
//   step      : one-cycle strobe, led is new on this cycle
//   led       : observed lamp pattern, bit 2 = left lamp
//   dir       : decoded direction (00 calm, 01 right-to-left, 10 left-to-right)
//   dir_valid : dir is confirmed and current
//   err       : one-cycle pulse on an illegal pattern or transition
module wind_light_decoder
    import wind_pkg::*;
#(
    parameter int CONFIRM = 2,
    parameter int TIMEOUT = 100
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       step,
    input  logic [2:0] led,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic       err
);

    localparam int         CW     = $clog2(TIMEOUT + 1);
    localparam logic [2:0] C_CONF = 3'(CONFIRM);
    localparam logic [CW-1:0] C_TO = CW'(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t        r_state,  w_state_nxt;
    logic [2:0]    r_prev,   w_prev_nxt;
    dir_t          r_cand,   w_cand_nxt;
    logic [2:0]    r_streak, w_streak_nxt;
    dir_t          r_dir,    w_dir_nxt;
    logic          r_valid,  w_valid_nxt;
    logic          r_err,    w_err_nxt;
    logic [CW-1:0] r_cnt,    w_cnt_nxt;
    xclass_t       w_xclass;
    dir_t          w_xdir;

    wind_xition_classify u_classify (
        .prev   (r_prev),
        .cur    (led),
        .xclass (w_xclass)
    );

    assign w_xdir = xclass_to_dir(w_xclass);

    // State and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_prev   <= 3'b000;
            r_cand   <= CALM;
            r_streak <= 3'd0;
            r_dir    <= CALM;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_prev   <= w_prev_nxt;
            r_cand   <= w_cand_nxt;
            r_streak <= w_streak_nxt;
            r_dir    <= w_dir_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Next-state: step processing, streak tracking and staleness timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev;
        w_cand_nxt   = r_cand;
        w_streak_nxt = r_streak;
        w_dir_nxt    = r_dir;
        w_valid_nxt  = r_valid;
        w_err_nxt    = 1'b0;
        w_cnt_nxt    = r_cnt;

        if (step) begin
            // A step always wins over a simultaneous timeout.
            w_cnt_nxt = '0;
            case (r_state)
                S_IDLE: begin
                    if (pattern_legal(led)) begin
                        w_prev_nxt   = led;
                        w_streak_nxt = 3'd0;
                        w_state_nxt  = S_TRACK;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                S_TRACK: begin
                    case (w_xclass)
                        X_CALM, X_R2L, X_L2R: begin
                            w_prev_nxt = led;
                            if (w_xdir == r_cand) begin
                                w_streak_nxt = (r_streak >= C_CONF) ? C_CONF
                                                                    : r_streak + 3'd1;
                            end else begin
                                w_cand_nxt   = w_xdir;
                                w_streak_nxt = 3'd1;
                            end
                            // Previous dir stays up until the new candidate confirms.
                            if (w_streak_nxt == C_CONF) begin
                                w_dir_nxt   = w_cand_nxt;
                                w_valid_nxt = 1'b1;
                            end else begin
                                w_dir_nxt   = r_dir;
                            end
                        end
                        X_NEUTRAL: begin
                            w_prev_nxt   = led;
                            w_streak_nxt = 3'd0;
                        end
                        default: begin
                            w_err_nxt    = 1'b1;
                            w_valid_nxt  = 1'b0;
                            w_streak_nxt = 3'd0;
                            // A legal repeat keeps tracking; garbage drops sync.
                            if (pattern_legal(led)) begin
                                w_prev_nxt = led;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    endcase
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else begin
            w_cnt_nxt = (r_cnt >= C_TO) ? C_TO : r_cnt + CW'(1);
            if (w_cnt_nxt == C_TO) begin
                w_valid_nxt  = 1'b0;
                w_state_nxt  = S_IDLE;
                w_streak_nxt = 3'd0;
            end else begin
                w_valid_nxt  = r_valid;
            end
        end
    end

    assign dir       = r_dir;
    assign dir_valid = r_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_wind_light_decoder.sv
// tb_wind_light_decoder
// Directed bench for wind_light_decoder with CONFIRM = 2, TIMEOUT = 8.
// Expected outputs are pushed to a scoreboard queue when a step is driven and
// popped/compared one clock edge later.
module tb_wind_light_decoder;

    logic       CLOCK_50;
    logic       reset;
    logic       step;
    logic [2:0] led;
    logic [1:0] dir;
    logic       dir_valid;
    logic       err;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string      tag;
        logic [1:0] d;
        logic       v;
        logic       e;
    } exp_t;

    exp_t sb_q[$];

    wind_light_decoder #(
        .CONFIRM (2),
        .TIMEOUT (8)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .step      (step),
        .led       (led),
        .dir       (dir),
        .dir_valid (dir_valid),
        .err       (err)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic expect_out(input string tag, input logic [1:0] d,
                              input logic v, input logic e);
        exp_t x;
        x.tag = tag; x.d = d; x.v = v; x.e = e;
        sb_q.push_back(x);
    endtask

    // Pop the oldest expectation and compare all three outputs.
    task automatic check_out();
        exp_t x;
        n_total++;
        assert (sb_q.size() > 0) n_pass++;
        else $error("FAIL scoreboard_empty: got size %0d, need >0", sb_q.size());
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            n_total++;
            assert (dir === x.d) n_pass++;
            else $error("FAIL %s dir: got %b, need %b", x.tag, dir, x.d);
            n_total++;
            assert (dir_valid === x.v) n_pass++;
            else $error("FAIL %s dir_valid: got %b, need %b", x.tag, dir_valid, x.v);
            n_total++;
            assert (err === x.e) n_pass++;
            else $error("FAIL %s err: got %b, need %b", x.tag, err, x.e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [1:0] d,
                             input logic v, input logic e);
        expect_out(tag, d, v, e);
        check_out();
    endtask

    task automatic tick_check(input string tag, input logic [1:0] d,
                              input logic v, input logic e);
        expect_out(tag, d, v, e);
        @(posedge CLOCK_50);
        #1;
        check_out();
    endtask

    // Drive one step; outputs are checked #1 after the sampling edge.
    task automatic do_step(input logic [2:0] p, input string tag,
                           input logic [1:0] d, input logic v, input logic e);
        step = 1'b1;
        led  = p;
        expect_out(tag, d, v, e);
        @(posedge CLOCK_50);
        #1;
        step = 1'b0;
        check_out();
    endtask

    task automatic step4(input logic [2:0] p, input string tag,
                         input logic [1:0] d, input logic v, input logic e);
        do_step(p, tag, d, v, e);
        idle(3);
    endtask

    initial begin
        reset = 1'b1;
        step  = 1'b0;
        led   = 3'b000;

        // 1: reset and idle
        idle(2);
        reset = 1'b0;
        check_now("reset_vals", 2'b00, 1'b0, 1'b0);
        idle(8);
        check_now("idle_after_reset", 2'b00, 1'b0, 1'b0);

        // 2: calm confirms on the third step
        step4(3'b010, "calm_s1", 2'b00, 1'b0, 1'b0);
        step4(3'b101, "calm_s2", 2'b00, 1'b0, 1'b0);
        step4(3'b010, "calm_s3", 2'b00, 1'b1, 1'b0);
        step4(3'b101, "calm_s4", 2'b00, 1'b1, 1'b0);

        // 3: right-to-left, then change to left-to-right without a valid drop
        step4(3'b010, "r2l_calm_sat", 2'b00, 1'b1, 1'b0);
        step4(3'b100, "r2l_s1",       2'b00, 1'b1, 1'b0);
        step4(3'b001, "r2l_conf",     2'b01, 1'b1, 1'b0);
        step4(3'b010, "r2l_sat",      2'b01, 1'b1, 1'b0);
        step4(3'b001, "l2r_s1_hold",  2'b01, 1'b1, 1'b0);
        step4(3'b100, "l2r_conf",     2'b10, 1'b1, 1'b0);

        // 4: neutral edge holds dir
        step4(3'b101, "neutral_hold", 2'b10, 1'b1, 1'b0);
        step4(3'b010, "calm_cand",    2'b10, 1'b1, 1'b0);

        // 5: errors from a confirmed state at prev 001
        step4(3'b001, "l2r_a",        2'b10, 1'b1, 1'b0);
        step4(3'b100, "l2r_b",        2'b10, 1'b1, 1'b0);
        step4(3'b010, "l2r_c",        2'b10, 1'b1, 1'b0);
        step4(3'b001, "l2r_d",        2'b10, 1'b1, 1'b0);
        do_step(3'b001, "repeat_err", 2'b10, 1'b0, 1'b1);
        tick_check("err_one_cycle",   2'b10, 1'b0, 1'b0);
        idle(2);
        do_step(3'b011, "illegal_pat", 2'b10, 1'b0, 1'b1);
        tick_check("err2_one_cycle",  2'b10, 1'b0, 1'b0);
        idle(2);
        step4(3'b010, "reload_s1",    2'b10, 1'b0, 1'b0);
        step4(3'b101, "reload_s2",    2'b10, 1'b0, 1'b0);
        step4(3'b010, "reload_conf",  2'b00, 1'b1, 1'b0);

        // 6a: confirm R2L, step exactly at the timeout edge, then go stale
        step4(3'b100, "to_r2l_s1",    2'b00, 1'b1, 1'b0);
        do_step(3'b001, "to_r2l_conf", 2'b01, 1'b1, 1'b0);
        idle(7);
        do_step(3'b010, "step_wins_timeout", 2'b01, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick_check($sformatf("stale_c%0d", k), 2'b01, (k < 8), 1'b0);
        end
        idle(3);
        step4(3'b100, "idle_after_stale", 2'b01, 1'b0, 1'b0);

        // 6b: reset mid-streak
        step4(3'b001, "pre_reset_s1", 2'b01, 1'b0, 1'b0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check_now("mid_reset_vals", 2'b00, 1'b0, 1'b0);
        step4(3'b010, "post_reset_s1", 2'b00, 1'b0, 1'b0);
        step4(3'b100, "post_reset_s2", 2'b00, 1'b0, 1'b0);
        step4(3'b001, "post_reset_s3", 2'b01, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
